// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes used by decode/immediate logic,
// fetch constants and the fetch FSM state type.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/ready
// handshake and holds the fetched word in the IF/ID register for decode.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instruction
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  pc;
  logic         xfer;
  logic         consume;

  // A fetch may issue only when decode can take the word, either because the
  // register is empty or because its current contents leave this cycle.
  always_comb begin
    imem_req = (state == FETCH) && !redirect && (!if_valid || !stall);
  end

  assign imem_addr = pc;
  assign xfer      = imem_req && imem_ready;
  assign consume   = if_valid && !stall && !xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // HOLD is entered only when a word lands while decode is stalled; a register
  // that was filled unstalled stays in FETCH so release refetches immediately.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        BOOT:    state_nxt = FETCH;
        FETCH:   if (xfer && stall) state_nxt = HOLD;
        HOLD:    if (!stall) state_nxt = FETCH;
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      if_valid       <= 1'b0;
      if_pc          <= RESET_PC;
      if_pc_plus4    <= RESET_PC + 32'd4;
      if_instruction <= NOP_INSTR;
    end else if (redirect) begin
      pc             <= redirect_pc & 32'hFFFF_FFFC;
      if_valid       <= 1'b0;
      if_instruction <= NOP_INSTR;
    end else if (xfer) begin
      pc             <= pc + 32'd4;
      if_valid       <= 1'b1;
      if_pc          <= pc;
      if_pc_plus4    <= pc + 32'd4;
      if_instruction <= imem_rdata;
    end else if (consume) begin
      if_valid       <= 1'b0;
      if_instruction <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// traffic compared against a behavioural model of the fetch stage.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instruction;

  int total = 0;
  int bad   = 0;

  // Behavioural model: "booting" and "parked" (word landed under stall)
  // flags plus the next-fetch PC and the contents of the IF/ID register.
  logic        m_boot;
  logic        m_parked;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instruction (if_instruction)
  );

  always #5 clk = ~clk;

  function automatic logic model_req();
    return !m_boot && !m_parked && !redirect && (!m_valid || !stall);
  endfunction

  // Advances one clock edge and moves the model along with it; no checking.
  task automatic tick();
    logic take;
    @(posedge clk);
    take = model_req() && imem_ready;
    if (rst) begin
      m_boot = 1'b1; m_parked = 1'b0; m_pc = 32'h0;
      m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP;
    end else if (redirect) begin
      m_boot = 1'b0; m_parked = 1'b0;
      m_pc = redirect_pc - {30'd0, redirect_pc[1:0]};
      m_valid = 1'b0; m_instr = NOP;
    end else begin
      m_boot = 1'b0;
      m_parked = stall && (m_parked || take);
      if (take) begin
        m_valid = 1'b1; m_ipc = m_pc; m_instr = imem_rdata;
        m_pc = m_pc + 32'd4;
      end else if (m_valid && !stall) begin
        m_valid = 1'b0; m_instr = NOP;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    tick();
    tick();
    total++;
    if ({imem_req, if_valid, if_pc, if_pc_plus4, if_instruction} !== {1'b0, 1'b0, 32'h0, 32'h4, NOP}) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got req=%b v=%b pc=%h p4=%h ins=%h want 0 0 0 4 13",
               imem_req, if_valid, if_pc, if_pc_plus4, if_instruction);
    end
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    #1;
    total++;
    if ({imem_req, if_valid} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL boot_idle: got req=%b valid=%b want 0 0", imem_req, if_valid);
    end
    tick();
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      bad++;
      $display("[TB] FAIL first_req: got req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
    tick();
    total++;
    if ({if_valid, if_pc, if_pc_plus4, if_instruction} !== {1'b1, 32'h0, 32'h4, 32'h0050_0093}) begin
      bad++;
      $display("[TB] FAIL stream_first: got v=%b pc=%h p4=%h ins=%h want 1 0 4 00500093",
               if_valid, if_pc, if_pc_plus4, if_instruction);
    end
    imem_rdata = 32'h00A0_0113;
    tick();
    total++;
    if ({if_valid, if_pc, if_pc_plus4, if_instruction} !== {1'b1, 32'h4, 32'h8, 32'h00A0_0113}) begin
      bad++;
      $display("[TB] FAIL stream_second: got v=%b pc=%h p4=%h ins=%h want 1 4 8 00a00113",
               if_valid, if_pc, if_pc_plus4, if_instruction);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = $urandom;
      #1;
      total++;
      if (imem_req !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_noreq: got %b want 0 (cycle %0d)", imem_req, i);
      end
      tick();
      total++;
      if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h4, 32'h00A0_0113}) begin
        bad++;
        $display("[TB] FAIL stall_hold: got v=%b pc=%h ins=%h want 1 4 00a00113",
                 if_valid, if_pc, if_instruction);
      end
    end
    stall = 1'b0; imem_rdata = 32'h0010_0193;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
      bad++;
      $display("[TB] FAIL stall_release_req: got req=%b addr=%h want 1 00000008", imem_req, imem_addr);
    end
    tick();
    total++;
    if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h8, 32'h0010_0193}) begin
      bad++;
      $display("[TB] FAIL stall_release: got v=%b pc=%h ins=%h want 1 8 00100193",
               if_valid, if_pc, if_instruction);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h0000_0103; stall = 1'b1; imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL redirect_noreq: got %b want 0", imem_req);
    end
    tick();
    redirect = 1'b0; stall = 1'b0; imem_rdata = 32'h1234_5013;
    #1;
    total++;
    if ({if_valid, if_instruction, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h100}) begin
      bad++;
      $display("[TB] FAIL redirect_flush: got v=%b ins=%h req=%b addr=%h want 0 13 1 00000100",
               if_valid, if_instruction, imem_req, imem_addr);
    end
    tick();
    total++;
    if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h100, 32'h1234_5013}) begin
      bad++;
      $display("[TB] FAIL redirect_target: got v=%b pc=%h ins=%h want 1 100 12345013",
               if_valid, if_pc, if_instruction);
    end
  endtask

  task automatic test_mem_wait();
    redirect = 1'b1; redirect_pc = 32'h0000_000C;
    tick();
    redirect = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_0C13;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (imem_addr !== 32'h10) begin
        bad++;
        $display("[TB] FAIL wait_addr: got %h want 00000010 (cycle %0d)", imem_addr, i);
      end
      tick();
      total++;
      if (if_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL wait_drain: got valid=%b want 0 (cycle %0d)", if_valid, i);
      end
    end
    imem_ready = 1'b1; imem_rdata = 32'h0000_1013;
    tick();
    total++;
    if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h10, 32'h0000_1013}) begin
      bad++;
      $display("[TB] FAIL wait_resume: got v=%b pc=%h ins=%h want 1 10 00001013",
               if_valid, if_pc, if_instruction);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; imem_ready = 1'b1; imem_rdata = $urandom;
    tick();
    total++;
    if ({if_valid, if_pc, if_pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      bad++;
      $display("[TB] FAIL wrap_last: got v=%b pc=%h p4=%h want 1 fffffffc 0",
               if_valid, if_pc, if_pc_plus4);
    end
    tick();
    total++;
    if ({if_valid, if_pc, if_pc_plus4} !== {1'b1, 32'h0, 32'h4}) begin
      bad++;
      $display("[TB] FAIL wrap_zero: got v=%b pc=%h p4=%h want 1 0 4",
               if_valid, if_pc, if_pc_plus4);
    end
  endtask

  task automatic test_reset_hold();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0; stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0000_4013;
    tick();
    #1;
    total++;
    if ({imem_req, if_valid, if_pc} !== {1'b0, 1'b1, 32'h40}) begin
      bad++;
      $display("[TB] FAIL hold_entered: got req=%b v=%b pc=%h want 0 1 40", imem_req, if_valid, if_pc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instruction} !==
        {1'b0, 32'h0, 1'b0, 32'h0, 32'h4, NOP}) begin
      bad++;
      $display("[TB] FAIL hold_reset: got req=%b addr=%h v=%b pc=%h p4=%h ins=%h want 0 0 0 0 4 13",
               imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instruction);
    end
    stall = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      stall       = ($urandom_range(0, 2) == 0);
      imem_ready  = ($urandom_range(0, 3) != 0);
      imem_rdata  = $urandom;
      #1;
      total++;
      if (!m_boot && {imem_req, imem_addr} !== {model_req(), m_pc}) begin
        bad++;
        $display("[TB] FAIL rand_fetch: got req=%b addr=%h want %b %h (iter %0d)",
                 imem_req, imem_addr, model_req(), m_pc, i);
      end
      tick();
      total++;
      if ({if_valid, if_pc, if_pc_plus4, if_instruction} !== {m_valid, m_ipc, m_ipc + 32'd4, m_instr}) begin
        bad++;
        $display("[TB] FAIL rand_ifid: got v=%b pc=%h p4=%h ins=%h want %b %h %h %h (iter %0d)",
                 if_valid, if_pc, if_pc_plus4, if_instruction,
                 m_valid, m_ipc, m_ipc + 32'd4, m_instr, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_mem_wait();
    test_wrap();
    test_reset_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
